// File: rtl/hamming_pkg.sv
// Shared constants, FSM state type and position helpers
// for the serial extended-Hamming receive controller.
package hamming_pkg;

  localparam int BLK_LOG2 = 4;
  localparam int BLK_LEN  = 1 << BLK_LOG2;
  localparam int DATA_W   = BLK_LEN - BLK_LOG2 - 1;

  typedef enum logic [1:0] {
    RECV,
    CHECK,
    OUT
  } state_e;

  // True for check-bit positions 1, 2, 4, 8, ...
  function automatic logic is_pow2(input int p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data-word bit index for a non-check, non-zero position.
  function automatic logic [BLK_LOG2-1:0] data_index(input int pos);
    logic [BLK_LOG2-1:0] idx;
    idx = '0;
    for (int i = 1; i < BLK_LEN; i++)
      if (i < pos && !is_pow2(i))
        idx += BLK_LOG2'(1);
    return idx;
  endfunction

endpackage

// File: rtl/hamming_syndrome_acc.sv
// Serial syndrome and overall-parity accumulator:
// XORs the address of every accepted one-bit into the syndrome.
module hamming_syndrome_acc
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_i,
  input  logic [BLK_LOG2-1:0] addr_i,
  input  logic                en_i,
  input  logic                clr_i,
  output logic [BLK_LOG2-1:0] syndrome_o,
  output logic                parity_o
);

  logic [BLK_LOG2-1:0] syn_q;
  logic                par_q;

  // Clear wins over accumulation; zero bits leave both untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (clr_i) begin
      syn_q <= '0;
      par_q <= 1'b0;
    end else if (en_i && bit_i) begin
      syn_q <= syn_q ^ addr_i;
      par_q <= ~par_q;
    end
  end

  assign syndrome_o = syn_q;
  assign parity_o   = par_q;

endmodule

// File: rtl/hamming_rx_ctrl.sv
// Receive controller: serial code bits in, corrected data word out.
// Define HAMMING_ERR_CNT_EN to add saturating single/double error counters.
module hamming_rx_ctrl
  import hamming_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sin,
  input  logic                sin_valid,
  output logic                sin_ready,
  input  logic                abort,
  output logic [DATA_W-1:0]   dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                err_single,
  output logic                err_double,
  output logic [BLK_LOG2-1:0] err_pos,
`ifdef HAMMING_ERR_CNT_EN
  output logic [15:0]         cnt_single,
  output logic [15:0]         cnt_double,
`endif
  output logic                busy
);

  state_e              state_q;
  logic [BLK_LOG2-1:0] a_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dv_q;
  logic                es_q, es_d;
  logic                ed_q, ed_d;
  logic [BLK_LOG2-1:0] ep_q, ep_d;
  logic [BLK_LOG2-1:0] syn;
  logic                par;
  logic                accept;
  logic                take;

  assign sin_ready = (state_q == RECV);
  assign accept    = sin_ready && sin_valid && !abort;
  assign take      = (state_q == OUT) && dout_ready && !abort;

  hamming_syndrome_acc u_acc (
    .clk        (clk),
    .rst        (rst),
    .bit_i      (sin),
    .addr_i     (a_q),
    .en_i       (accept),
    .clr_i      (abort || take),
    .syndrome_o (syn),
    .parity_o   (par)
  );

  // Classify the finished block and correct a flipped data bit.
  always_comb begin
    dout_d = data_q;
    es_d   = 1'b0;
    ed_d   = 1'b0;
    ep_d   = '0;
    if (par) begin
      es_d = 1'b1;
      ep_d = syn;
      if (syn != '0 && !is_pow2(int'(syn)))
        dout_d[data_index(int'(syn))] = ~data_q[data_index(int'(syn))];
    end else if (syn != '0) begin
      ed_d = 1'b1;
    end
  end

  // Main FSM with registered word and flag outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RECV;
      a_q     <= '0;
      data_q  <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      es_q    <= 1'b0;
      ed_q    <= 1'b0;
      ep_q    <= '0;
    end else if (abort) begin
      state_q <= RECV;
      a_q     <= '0;
      dv_q    <= 1'b0;
      es_q    <= 1'b0;
      ed_q    <= 1'b0;
      ep_q    <= '0;
    end else begin
      unique case (state_q)
        RECV: begin
          if (sin_valid) begin
            if (a_q != '0 && !is_pow2(int'(a_q)))
              data_q[data_index(int'(a_q))] <= sin;
            a_q <= a_q + BLK_LOG2'(1);
            if (&a_q)
              state_q <= CHECK;
          end
        end
        CHECK: begin
          dout_q  <= dout_d;
          es_q    <= es_d;
          ed_q    <= ed_d;
          ep_q    <= ep_d;
          dv_q    <= 1'b1;
          state_q <= OUT;
        end
        OUT: begin
          if (dout_ready) begin
            dv_q    <= 1'b0;
            es_q    <= 1'b0;
            ed_q    <= 1'b0;
            ep_q    <= '0;
            state_q <= RECV;
          end
        end
        default: state_q <= RECV;
      endcase
    end
  end

`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] cs_q;
  logic [15:0] cd_q;

  // Count delivered words by flag, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q <= '0;
      cd_q <= '0;
    end else if (take) begin
      if (es_q && cs_q != 16'hFFFF)
        cs_q <= cs_q + 16'd1;
      if (ed_q && cd_q != 16'hFFFF)
        cd_q <= cd_q + 16'd1;
    end
  end

  assign cnt_single = cs_q;
  assign cnt_double = cd_q;
`endif

  assign dout       = dout_q;
  assign dout_valid = dv_q;
  assign err_single = es_q;
  assign err_double = ed_q;
  assign err_pos    = ep_q;
  assign busy       = (state_q != RECV) || (a_q != '0);

endmodule

// File: tb/tb_hamming_rx_ctrl.sv
// Self-checking bench for hamming_rx_ctrl: directed cases plus
// random codewords with injected errors against an encoder model.
module tb_hamming_rx_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        sin;
  logic        sin_valid;
  logic        sin_ready;
  logic        abort;
  logic [10:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        err_single;
  logic        err_double;
  logic [3:0]  err_pos;
  logic        busy;
`ifdef HAMMING_ERR_CNT_EN
  logic [15:0] cnt_single;
  logic [15:0] cnt_double;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cs = 0;
  int exp_cd = 0;

  always #5 clk = ~clk;

  hamming_rx_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_ready  (sin_ready),
    .abort      (abort),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .err_single (err_single),
    .err_double (err_double),
    .err_pos    (err_pos),
`ifdef HAMMING_ERR_CNT_EN
    .cnt_single (cnt_single),
    .cnt_double (cnt_double),
`endif
    .busy       (busy)
  );

  function automatic bit pow2(input int p);
    return (p != 0) && ((p & (p - 1)) == 0);
  endfunction

  // Build a valid extended-Hamming codeword from 11 data bits.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int k;
    c = '0;
    k = 0;
    for (int p = 1; p < 16; p++)
      if (!pow2(p)) begin
        c[p[3:0]] = d[k[3:0]];
        k++;
      end
    for (int b = 0; b < 4; b++) begin
      int cp;
      cp = 1 << b;
      for (int p = 1; p < 16; p++)
        if (!pow2(p) && ((p >> b) & 1) != 0)
          c[cp[3:0]] = c[cp[3:0]] ^ c[p[3:0]];
    end
    c[0] = ^c[15:1];
    return c;
  endfunction

  function automatic logic [10:0] extract(input logic [15:0] c);
    logic [10:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p < 16; p++)
      if (!pow2(p)) begin
        d[k[3:0]] = c[p[3:0]];
        k++;
      end
    return d;
  endfunction

  // Present the first n bits of blk; returns 1 ns after the last accept.
  task automatic send_bits(input logic [15:0] blk, input int n,
                           input bit gaps);
    int w;
    for (int p = 0; p < n; p++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(negedge clk);
        sin_valid = 1'b0;
      end
      @(negedge clk);
      sin       = blk[p[3:0]];
      sin_valid = 1'b1;
      w = 0;
      while (!sin_ready && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!sin_ready) begin
        checks++;
        errors++;
        $display("FAIL send_timeout pos=%0d sin_ready=%b want 1",
                 p, sin_ready);
        sin_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    sin_valid = 1'b0;
  endtask

  // Wait for a word, compare it, then hand it off after `hold` stalls.
  task automatic get_word(input logic [10:0] ed, input logic es,
                          input logic edbl, input logic [3:0] ep,
                          input string nm, input int hold);
    int w;
    w = 0;
    while (!dout_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid dout_valid=%b want 1", nm, dout_valid);
      return;
    end
    checks++;
    if (dout !== ed || err_single !== es || err_double !== edbl ||
        err_pos !== ep) begin
      errors++;
      $display("FAIL %s_word got %h s%b d%b p%0d want %h s%b d%b p%0d",
               nm, dout, err_single, err_double, err_pos,
               ed, es, edbl, ep);
    end
    repeat (hold) @(negedge clk);
    @(negedge clk);
    dout_ready = 1'b1;
    @(posedge clk);
    #1;
    dout_ready = 1'b0;
    if (es) exp_cs++;
    if (edbl) exp_cd++;
    checks++;
    if (dout_valid !== 1'b0 || err_single !== 1'b0 ||
        err_double !== 1'b0 || sin_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_release v=%b s=%b d=%b rdy=%b want 0 0 0 1",
               nm, dout_valid, err_single, err_double, sin_ready);
    end
  endtask

  task automatic check_counters(input string nm);
`ifdef HAMMING_ERR_CNT_EN
    checks++;
    if (cnt_single !== 16'(exp_cs) || cnt_double !== 16'(exp_cd)) begin
      errors++;
      $display("FAIL %s_cnt got %0d/%0d want %0d/%0d", nm,
               cnt_single, cnt_double, exp_cs, exp_cd);
    end
`else
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle busy=%b want 0", nm, busy);
    end
`endif
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    sin        = 1'b0;
    sin_valid  = 1'b0;
    abort      = 1'b0;
    dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_cs = 0;
    exp_cd = 0;
    @(negedge clk);
    checks++;
    if (sin_ready !== 1'b1 || dout_valid !== 1'b0 || dout !== 11'h000 ||
        err_single !== 1'b0 || err_double !== 1'b0 ||
        err_pos !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset rdy=%b v=%b dout=%h s=%b d=%b p=%0d busy=%b",
               sin_ready, dout_valid, dout, err_single, err_double,
               err_pos, busy);
    end
    check_counters("reset");
  endtask

  task automatic test_zero_latency();
    send_bits(16'h0000, 16, 1'b0);
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b1 || sin_ready !== 1'b0) begin
      errors++;
      $display("FAIL lat_check v=%b busy=%b rdy=%b want 0 1 0",
               dout_valid, busy, sin_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL lat_out dout_valid=%b want 1", dout_valid);
    end
    get_word(11'h000, 1'b0, 1'b0, 4'd0, "zero", 0);
  endtask

  task automatic test_directed();
    logic [15:0] b;
    b = 16'hFFFF;
    b[6] = 1'b0;
    send_bits(b, 16, 1'b1);
    get_word(11'h7FF, 1'b1, 1'b0, 4'd6, "pos6", 1);
    send_bits(16'h0028, 16, 1'b1);
    get_word(11'h003, 1'b0, 1'b1, 4'd0, "dbl35", 0);
    send_bits(16'h0001, 16, 1'b1);
    get_word(11'h000, 1'b1, 1'b0, 4'd0, "pos0", 2);
    check_counters("directed");
  endtask

  task automatic test_backpressure();
    logic [15:0] b;
    b = encode(11'h5A3);
    send_bits(b, 16, 1'b0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sin       = 1'b1;
      sin_valid = 1'b1;
      checks++;
      if (sin_ready !== 1'b0 || dout_valid !== 1'b1 ||
          dout !== 11'h5A3 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold%0d rdy=%b v=%b dout=%h busy=%b", i,
                 sin_ready, dout_valid, dout, busy);
      end
    end
    sin_valid = 1'b0;
    get_word(11'h5A3, 1'b0, 1'b0, 4'd0, "bp", 0);
    b = encode(11'h2C6);
    b[12] = ~b[12];
    send_bits(b, 16, 1'b1);
    get_word(11'h2C6, 1'b1, 1'b0, 4'd12, "bp_next", 0);
  endtask

  task automatic test_reset_abort();
    send_bits(16'hFFFF, 7, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cs = 0;
    exp_cd = 0;
    checks++;
    if (busy !== 1'b0 || sin_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst busy=%b rdy=%b want 0 1", busy, sin_ready);
    end
    send_bits(16'hFFFF, 16, 1'b1);
    get_word(11'h7FF, 1'b0, 1'b0, 4'd0, "after_rst", 0);
    send_bits(16'hFFFF, 9, 1'b0);
    @(negedge clk);
    abort     = 1'b1;
    sin       = 1'b1;
    sin_valid = 1'b1;
    @(posedge clk);
    #1;
    abort     = 1'b0;
    sin_valid = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_recv busy=%b want 0", busy);
    end
    send_bits(16'hFFFF, 16, 1'b1);
    get_word(11'h7FF, 1'b0, 1'b0, 4'd0, "after_abort", 0);
    check_counters("rst_abort");
  endtask

  task automatic test_abort_out();
    logic [15:0] b;
    b = encode(11'h111);
    b[9] = ~b[9];
    send_bits(b, 16, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || err_single !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_out v=%b s=%b busy=%b want 0 0 0",
               dout_valid, err_single, busy);
    end
    check_counters("abort_out");
    send_bits(encode(11'h6B4), 16, 1'b1);
    get_word(11'h6B4, 1'b0, 1'b0, 4'd0, "after_aout", 0);
  endtask

  task automatic test_random(input int n);
    logic [10:0] d;
    logic [15:0] b;
    logic [3:0]  e1;
    logic [3:0]  e2;
    int          ne;
    for (int t = 0; t < n; t++) begin
      d  = 11'($urandom);
      b  = encode(d);
      ne = $urandom_range(0, 2);
      e1 = 4'($urandom_range(0, 15));
      e2 = e1 + 4'($urandom_range(1, 15));
      if (ne >= 1) b[e1] = ~b[e1];
      if (ne == 2) b[e2] = ~b[e2];
      send_bits(b, 16, 1'b1);
      if (ne == 0)
        get_word(d, 1'b0, 1'b0, 4'd0, "rnd0", $urandom_range(0, 3));
      else if (ne == 1)
        get_word(d, 1'b1, 1'b0, e1, "rnd1", $urandom_range(0, 3));
      else
        get_word(extract(b), 1'b0, 1'b1, 4'd0, "rnd2",
                 $urandom_range(0, 3));
    end
    check_counters("random");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero_latency();
    test_reset_abort();
    test_directed();
    test_backpressure();
    test_abort_out();
    test_random(40);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
